// File: rtl/preamble_gate_pkg.sv
// preamble_gate_pkg: shared types and helpers for the preamble burst gate.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: state_t gate states, STAT_WIDTH statistics width, sat_inc saturating increment.
package preamble_gate_pkg;

  localparam int STAT_WIDTH = 48;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_BURST   = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] value);
    return (&value) ? value : value + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/sat_counter48.sv
// sat_counter48: 48-bit statistics counter, increments on inc, saturates at all-ones.
// Latency: count reflects an increment one cycle after inc is high.
// Backpressure: none; inc is sampled every cycle.
// Ports: clk, reset (sync, active-high), inc (count this cycle), count (current value).
module sat_counter48
  import preamble_gate_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  output logic [STAT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/preamble_burst_gate.sv
// preamble_burst_gate: drops samples until a detection (i_tlast) is seen while armed, then
//   forwards exactly burst_len samples with o_tlast on the last one; keeps burst/reject statistics.
// Latency: 0 cycles; the burst path is a combinational pass-through.
// Backpressure: in a burst i_tready follows o_tready; outside a burst input is always accepted and dropped.
// Build option: define PREAMBLE_GATE_HOLDOFF_EN to drop HOLDOFF input beats after each burst before re-arming.
// Ports: clk, reset (sync, active-high), enable (arm), burst_len (latched on detection),
//   i_tdata/i_tlast/i_tvalid/i_tready (detector stream, tlast = detection marker),
//   o_tdata/o_tlast/o_tvalid/o_tready (gated burst), active (in burst),
//   burst_count (bursts started), reject_count (detections ignored).
module preamble_burst_gate
  import preamble_gate_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          LEN_WIDTH = 16,
  parameter int unsigned HOLDOFF   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic [WIDTH-1:0]      i_tdata,
  input  logic                  i_tlast,
  input  logic                  i_tvalid,
  output logic                  i_tready,
  output logic [WIDTH-1:0]      o_tdata,
  output logic                  o_tlast,
  output logic                  o_tvalid,
  input  logic                  o_tready,
  output logic                  active,
  output logic [STAT_WIDTH-1:0] burst_count,
  output logic [STAT_WIDTH-1:0] reject_count
);

`ifdef PREAMBLE_GATE_HOLDOFF_EN
  localparam bit HOLD_ON = (HOLDOFF != 0);
`else
  // Holdoff compiled out: both builds share one parameter list, HOLDOFF has no effect here.
  localparam bit HOLD_ON = (HOLDOFF != 0) && 1'b0;
`endif

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] remaining, remaining_nxt;
  logic                 in_burst;
  logic                 beat;
  logic                 detect;
  logic                 last_beat;
  logic                 inc_burst;
  logic                 inc_reject;
`ifdef PREAMBLE_GATE_HOLDOFF_EN
  logic [31:0]          hold_cnt;
`endif

  // Output mux: pass-through in a burst, otherwise swallow everything.
  assign in_burst  = (state == S_BURST);
  assign i_tready  = in_burst ? o_tready : 1'b1;
  assign o_tvalid  = in_burst & i_tvalid;
  assign o_tdata   = i_tdata;
  assign o_tlast   = in_burst && (remaining == LEN_WIDTH'(1));
  assign active    = in_burst;

  assign beat      = i_tvalid & i_tready;
  assign detect    = beat & i_tlast;
  assign last_beat = beat && (remaining == LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
    end
  end

`ifdef PREAMBLE_GATE_HOLDOFF_EN
  // Reloaded throughout the burst so it holds the full window on entry to S_HOLDOFF.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (in_burst) begin
      hold_cnt <= HOLDOFF;
    end else if ((state == S_HOLDOFF) && beat) begin
      hold_cnt <= hold_cnt - 32'd1;
    end
  end
`endif

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    inc_burst     = 1'b0;
    inc_reject    = 1'b0;
    case (state)
      S_IDLE: begin
        inc_reject = detect;
        if (enable) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (!enable) begin
          inc_reject = detect;
          state_nxt  = S_IDLE;
        end else if (detect) begin
          // The detection beat itself is dropped; the burst begins on the next sample.
          if (burst_len != '0) begin
            remaining_nxt = burst_len;
            inc_burst     = 1'b1;
            state_nxt     = S_BURST;
          end else begin
            inc_reject = 1'b1;
          end
        end
      end
      S_BURST: begin
        if (beat) begin
          // A detection inside a burst is forwarded as data but never starts another burst.
          inc_reject    = i_tlast;
          remaining_nxt = remaining - LEN_WIDTH'(1);
        end
        if (last_beat) begin
          if (HOLD_ON) state_nxt = S_HOLDOFF;
          else         state_nxt = enable ? S_ARMED : S_IDLE;
        end
      end
`ifdef PREAMBLE_GATE_HOLDOFF_EN
      S_HOLDOFF: begin
        if (beat) begin
          inc_reject = i_tlast;
          if (hold_cnt == 32'd1) state_nxt = enable ? S_ARMED : S_IDLE;
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  sat_counter48 u_burst_count (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_burst),
    .count (burst_count)
  );

  sat_counter48 u_reject_count (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_reject),
    .count (reject_count)
  );

endmodule

// File: tb/tb_preamble_burst_gate.sv
// tb_preamble_burst_gate: directed scenarios plus randomized traffic against a behavioural model.
// Latency: n/a.
// Backpressure: o_tready driven randomly in the backpressure and random phases.
module tb_preamble_burst_gate;

  localparam int WIDTH = 32;
  localparam int LEN_WIDTH = 16;
`ifdef PREAMBLE_GATE_HOLDOFF_EN
  localparam int HOLD_M = 5;
`else
  localparam int HOLD_M = 0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic [LEN_WIDTH-1:0] burst_len;
  logic [WIDTH-1:0]     i_tdata;
  logic                 i_tlast;
  logic                 i_tvalid;
  logic                 i_tready;
  logic [WIDTH-1:0]     o_tdata;
  logic                 o_tlast;
  logic                 o_tvalid;
  logic                 o_tready;
  logic                 active;
  logic [47:0]          burst_count;
  logic [47:0]          reject_count;

  preamble_burst_gate #(.WIDTH(WIDTH), .LEN_WIDTH(LEN_WIDTH), .HOLDOFF(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .burst_len    (burst_len),
    .i_tdata      (i_tdata),
    .i_tlast      (i_tlast),
    .i_tvalid     (i_tvalid),
    .i_tready     (i_tready),
    .o_tdata      (o_tdata),
    .o_tlast      (o_tlast),
    .o_tvalid     (o_tvalid),
    .o_tready     (o_tready),
    .active       (active),
    .burst_count  (burst_count),
    .reject_count (reject_count)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model: samples left in the current burst, samples left in holdoff, armed flag, statistics.
  int          m_rem, m_hold;
  bit          m_armed;
  longint      m_bursts, m_rejects;
  int unsigned sample_id;
  logic [WIDTH-1:0] out_q[$];
  logic [WIDTH-1:0] last_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check combinational outputs, advance the model, check statistics.
  task automatic cycle(input bit en, input int len, input bit v, input bit tl, input bit rdy);
    bit burst_m, rdy_m, beat_m;
    @(negedge clk);
    enable    = en;
    burst_len = len[LEN_WIDTH-1:0];
    i_tvalid  = v;
    i_tlast   = tl;
    o_tready  = rdy;
    i_tdata   = sample_id;
    #2;
    burst_m = (m_rem > 0);
    rdy_m   = burst_m ? rdy : 1'b1;
    beat_m  = v && rdy_m;
    check("i_tready", i_tready, rdy_m);
    check("o_tvalid", o_tvalid, burst_m && v);
    check("active", active, burst_m);
    if (burst_m && v) begin
      check("o_tdata", o_tdata, sample_id);
      check("o_tlast", o_tlast, m_rem == 1);
    end
    if (o_tvalid && o_tready) begin
      out_q.push_back(o_tdata);
      if (o_tlast) last_q.push_back(o_tdata);
    end
    if (burst_m) begin
      if (beat_m) begin
        if (tl) m_rejects++;
        m_rem--;
        if (m_rem == 0) begin
          if (HOLD_M > 0) m_hold = HOLD_M;
          else            m_armed = en;
        end
      end
    end else if (m_hold > 0) begin
      if (beat_m) begin
        if (tl) m_rejects++;
        m_hold--;
        if (m_hold == 0) m_armed = en;
      end
    end else if (m_armed) begin
      if (!en) begin
        m_armed = 1'b0;
        if (beat_m && tl) m_rejects++;
      end else if (beat_m && tl) begin
        if (len != 0) begin
          m_rem = len;
          m_bursts++;
        end else begin
          m_rejects++;
        end
      end
    end else begin
      if (beat_m && tl) m_rejects++;
      if (en) m_armed = 1'b1;
    end
    if (beat_m) sample_id++;
    @(posedge clk);
    #1;
    check("burst_count", burst_count, m_bursts);
    check("reject_count", reject_count, m_rejects);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    i_tlast = 1'b0;
    @(posedge clk);
    #1;
    check("rst_o_tvalid", o_tvalid, 1'b0);
    check("rst_o_tlast", o_tlast, 1'b0);
    check("rst_active", active, 1'b0);
    check("rst_burst_count", burst_count, 0);
    check("rst_reject_count", reject_count, 0);
    @(negedge clk);
    reset     = 1'b0;
    enable    = 1'b0;
    i_tvalid  = 1'b0;
    m_rem     = 0;
    m_hold    = 0;
    m_armed   = 1'b0;
    m_bursts  = 0;
    m_rejects = 0;
    sample_id = 0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint      b0, r0;
    int unsigned start;
    reset = 1'b1; enable = 1'b0; burst_len = '0; i_tdata = '0;
    i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
    do_reset();

    // Detection on sample 10, burst of 4 -> samples 11..14, tlast on 14.
    cycle(1, 4, 0, 0, 1);
    out_q.delete(); last_q.delete();
    for (int i = 0; i <= 16; i++) cycle(1, 4, 1, (i == 10), 1);
    check("t1_out_count", out_q.size(), 4);
    for (int k = 0; k < 4 && k < out_q.size(); k++) check("t1_out_data", out_q[k], 11 + k);
    check("t1_tlast_count", last_q.size(), 1);
    if (last_q.size() > 0) check("t1_tlast_data", last_q[0], 14);
    check("t1_burst_count", burst_count, 1);

    // Burst of 100 under random valid and ready.
    out_q.delete(); last_q.delete();
    start = sample_id;
    cycle(1, 100, 1, 1, 1);
    for (int c = 0; c < 2000 && out_q.size() < 100; c++)
      cycle(1, 100, ($urandom % 4) != 0, 0, $urandom % 2);
    for (int c = 0; c < 5; c++) cycle(1, 100, 1, 0, 1);
    check("t2_out_count", out_q.size(), 100);
    for (int k = 0; k < 100 && k < out_q.size(); k++) check("t2_out_data", out_q[k], start + 1 + k);
    check("t2_tlast_count", last_q.size(), 1);

    // Disabled: three detections, all rejected, nothing forwarded.
    out_q.delete();
    r0 = m_rejects;
    cycle(0, 4, 0, 0, 1);
    for (int i = 0; i < 9; i++) cycle(0, 4, 1, (i % 3) == 1, 1);
    check("t3_out_count", out_q.size(), 0);
    check("t3_rejects", reject_count, r0 + 3);

    // Second detection inside a burst of 8.
    out_q.delete(); last_q.delete();
    b0 = m_bursts; r0 = m_rejects;
    cycle(1, 8, 0, 0, 1);
    cycle(1, 8, 1, 1, 1);
    for (int i = 0; i < 12; i++) cycle(1, 8, 1, (i == 3), 1);
    check("t4_out_count", out_q.size(), 8);
    check("t4_tlast_count", last_q.size(), 1);
    check("t4_bursts", burst_count, b0 + 1);
    check("t4_rejects", reject_count, r0 + 1);

    // burst_len = 0: rejected, gate stays armed for the next detection.
    out_q.delete();
    b0 = m_bursts; r0 = m_rejects;
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, (i == 1), 1);
    check("t5_out_count", out_q.size(), 0);
    check("t5_rejects", reject_count, r0 + 1);
    cycle(1, 2, 1, 1, 1);
    check("t5_rearmed_active", active, 1'b1);
    cycle(1, 2, 1, 0, 1);
    cycle(1, 2, 1, 0, 1);
    check("t5_bursts", burst_count, b0 + 1);

`ifdef PREAMBLE_GATE_HOLDOFF_EN
    // Holdoff of 5: detection 2 samples after a burst rejected, 6 samples after accepted.
    for (int i = 0; i < 10; i++) cycle(1, 2, 1, 0, 1);
    b0 = m_bursts; r0 = m_rejects;
    cycle(1, 2, 1, 1, 1);
    cycle(1, 2, 1, 0, 1);
    cycle(1, 2, 1, 0, 1);
    for (int i = 1; i <= 6; i++) cycle(1, 3, 1, (i == 2) || (i == 6), 1);
    check("t6_rejects", reject_count, r0 + 1);
    check("t6_bursts", burst_count, b0 + 2);
    check("t6_active", active, 1'b1);
`endif

    // Reset in the middle of a burst.
    last_q.delete();
    cycle(1, 20, 0, 0, 1);
    for (int i = 0; i < 6; i++) cycle(1, 20, 1, (i == 0), 1);
    @(negedge clk);
    i_tvalid = 1'b1;
    do_reset();
    check("t7_no_tlast", last_q.size(), 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++)
      cycle(($urandom % 16) != 0, $urandom % 7, ($urandom % 4) != 0, ($urandom % 10) == 0, ($urandom % 3) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
